// File: rtl/conv_pkg.sv
// Shared definitions for the sequential convolution layers: FSM states,
// default geometry constants and a counter-width helper.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  localparam int DEF_BITWIDTH = 32;
  localparam int DEF_CH       = 2;
  localparam int DEF_KS       = 5;
  localparam int DEF_NK       = 10;

  // Counters for a dimension of size 1 still need one bit to exist.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Sequential multiply-accumulate: accumulates one product per enabled cycle and
// clears on the last term. Optional feature macro: CONV_LAYER_SEQ_RELU_EN.
module conv_mac
  import conv_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                last_i,
  input  logic [BITWIDTH-1:0] a_i,
  input  logic [BITWIDTH-1:0] b_i,
  output logic [BITWIDTH-1:0] result_o
);

  logic [BITWIDTH-1:0] acc_q;
  logic [BITWIDTH-1:0] acc_d;
  logic [BITWIDTH-1:0] prod;
  logic [BITWIDTH-1:0] sum;

  // The low BITWIDTH bits of a product are identical for signed and unsigned operands.
  assign prod = a_i * b_i;
  assign sum  = acc_q + prod;

`ifdef CONV_LAYER_SEQ_RELU_EN
  assign result_o = sum[BITWIDTH-1] ? '0 : sum;
`else
  assign result_o = sum;
`endif

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = last_i ? '0 : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/conv_layer_seq.sv
// Sequential convolution layer: one MAC term per cycle over all kernels, one registered
// result per kernel. Optional feature macro: CONV_LAYER_SEQ_RELU_EN (applied in conv_mac).
module conv_layer_seq
  import conv_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int CH       = DEF_CH,
  parameter int KS       = DEF_KS,
  parameter int NK       = DEF_NK
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BITWIDTH-1:0]     featuremap_in  [CH][KS][KS],
  input  logic [BITWIDTH-1:0]     kernel         [NK][CH][KS][KS],
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  output logic [$clog2(NK)-1:0]   out_idx,
  output logic [BITWIDTH-1:0]     featuremap_out [NK]
);

  localparam int KW = cnt_w(NK);
  localparam int CW = cnt_w(CH);
  localparam int PW = cnt_w(KS);
  localparam int IW = $clog2(NK);

  localparam logic [KW-1:0] K_LAST = KW'(NK - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CH - 1);
  localparam logic [PW-1:0] P_LAST = PW'(KS - 1);

  conv_state_t         state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [CW-1:0]       c_q, c_d;
  logic [PW-1:0]       r_q, r_d;
  logic [PW-1:0]       x_q, x_d;
  logic                out_valid_q;
  logic [IW-1:0]       out_idx_q;
  logic [BITWIDTH-1:0] res_q [NK];

  logic                mac_en;
  logic                kern_last;
  logic                layer_last;
  logic                emit;
  logic [BITWIDTH-1:0] mac_a;
  logic [BITWIDTH-1:0] mac_b;
  logic [BITWIDTH-1:0] mac_result;

  assign kern_last  = (c_q == C_LAST) && (r_q == P_LAST) && (x_q == P_LAST);
  assign layer_last = kern_last && (k_q == K_LAST);
  assign emit       = mac_en && kern_last;

  assign mac_a = featuremap_in[c_q][r_q][x_q];
  assign mac_b = kernel[k_q][c_q][r_q][x_q];

  // Term order is k (outer), c, r, x (inner); x is the fastest-moving counter.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    r_d     = r_q;
    x_d     = x_q;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          c_d     = '0;
          r_d     = '0;
          x_d     = '0;
        end
      end
      RUN: begin
        mac_en = 1'b1;
        if (x_q == P_LAST) begin
          x_d = '0;
          if (r_q == P_LAST) begin
            r_d = '0;
            if (c_q == C_LAST) begin
              c_d = '0;
              k_d = (k_q == K_LAST) ? '0 : k_q + KW'(1);
            end else begin
              c_d = c_q + CW'(1);
            end
          end else begin
            r_d = r_q + PW'(1);
          end
        end else begin
          x_d = x_q + PW'(1);
        end
        if (layer_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      x_q         <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      c_q         <= c_d;
      r_q         <= r_d;
      x_q         <= x_d;
      out_valid_q <= emit;
      out_idx_q   <= IW'(k_q);
    end
  end

  conv_mac #(
    .BITWIDTH(BITWIDTH)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (mac_en),
    .last_i   (kern_last),
    .a_i      (mac_a),
    .b_i      (mac_b),
    .result_o (mac_result)
  );

  // Each result register only changes on its own kernel's last term, so old
  // results stay visible until a new run overwrites them one by one.
  generate
    for (genvar gi = 0; gi < NK; gi++) begin : g_res
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          res_q[gi] <= '0;
        end else if (emit && (k_q == KW'(gi))) begin
          res_q[gi] <= mac_result;
        end
      end
      assign featuremap_out[gi] = res_q[gi];
    end
  endgenerate

  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Self-checking bench for conv_layer_seq: directed and random layers against a
// plain-arithmetic reference model, plus restart, mid-run reset and back-to-back runs.
module tb_conv_layer_seq;

  localparam int BW    = 32;
  localparam int CH    = 2;
  localparam int KS    = 5;
  localparam int NK    = 10;
  localparam int TERMS = CH * KS * KS;
  localparam int N     = NK * TERMS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [BW-1:0] fm   [CH][KS][KS];
  logic [BW-1:0] kern [NK][CH][KS][KS];
  logic busy, done, out_valid;
  logic [$clog2(NK)-1:0] out_idx;
  logic [BW-1:0] fm_out [NK];

  logic [BW-1:0] expv [NK];
  int checks = 0;
  int failures = 0;

  int obs_done_cycle;
  int obs_done_count;
  logic obs_busy1;
  int vld_idx [$];
  int vld_cyc [$];
  logic [BW-1:0] vld_val [$];

  always #5 clk = ~clk;

  conv_layer_seq #(
    .BITWIDTH(BW), .CH(CH), .KS(KS), .NK(NK)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .featuremap_in  (fm),
    .kernel         (kern),
    .busy           (busy),
    .done           (done),
    .out_valid      (out_valid),
    .out_idx        (out_idx),
    .featuremap_out (fm_out)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: each result is the wrapped dot product of the map with one kernel.
  task automatic model();
    for (int k = 0; k < NK; k++) begin
      logic [BW-1:0] s;
      s = '0;
      for (int c = 0; c < CH; c++)
        for (int r = 0; r < KS; r++)
          for (int x = 0; x < KS; x++)
            s = s + fm[c][r][x] * kern[k][c][r][x];
`ifdef CONV_LAYER_SEQ_RELU_EN
      if ($signed(s) < 0) s = '0;
`endif
      expv[k] = s;
    end
  endtask

  task automatic fill_fm(input logic [BW-1:0] v);
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < KS; r++)
        for (int x = 0; x < KS; x++)
          fm[c][r][x] = v;
  endtask

  task automatic fill_kern(input int k, input logic [BW-1:0] v);
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < KS; r++)
        for (int x = 0; x < KS; x++)
          kern[k][c][r][x] = v;
  endtask

  // Drives one start pulse from the current negedge and records observations for
  // cycles 1..len (cycle 1 is the cycle after the edge that samples start).
  task automatic run_layer(input int len, input int repulse_at, input int reset_at);
    vld_idx.delete();
    vld_cyc.delete();
    vld_val.delete();
    obs_done_cycle = -1;
    obs_done_count = 0;
    obs_busy1 = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= len; cyc++) begin
      if (cyc == 1) obs_busy1 = busy;
      if (done === 1'b1) begin
        if (obs_done_count == 0) obs_done_cycle = cyc;
        obs_done_count++;
      end
      if (out_valid === 1'b1) begin
        vld_idx.push_back(int'(out_idx));
        vld_cyc.push_back(cyc);
        vld_val.push_back(fm_out[out_idx]);
      end
      start = (cyc == repulse_at);
      rst_n = !(reset_at > 0 && cyc >= reset_at && cyc < reset_at + 2);
      if (cyc < len) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_idx !== '0) begin failures++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (fm_out[k] !== '0) begin failures++; $display("FAIL reset_fm_out[%0d]: got %h expected 0", k, fm_out[k]); end
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_all_ones();
    fill_fm(32'd1);
    for (int k = 0; k < NK; k++) fill_kern(k, 32'd1);
    run_layer(N + 10, 0, 0);
    checks++; if (obs_busy1 !== 1'b1) begin failures++; $display("FAIL ones_busy_cycle1: got %b expected 1", obs_busy1); end
    checks++; if (obs_done_cycle != N + 1) begin failures++; $display("FAIL ones_done_cycle: got %0d expected %0d", obs_done_cycle, N + 1); end
    checks++; if (obs_done_count != 1) begin failures++; $display("FAIL ones_done_count: got %0d expected 1", obs_done_count); end
    checks++; if (vld_idx.size() != NK) begin failures++; $display("FAIL ones_valid_count: got %0d expected %0d", vld_idx.size(), NK); end
    for (int i = 0; i < NK && i < vld_idx.size(); i++) begin
      checks++;
      if (vld_idx[i] != i || vld_cyc[i] != (i + 1) * TERMS + 1 || vld_val[i] !== 32'd50) begin
        failures++;
        $display("FAIL ones_valid[%0d]: got idx=%0d cyc=%0d val=%0d expected idx=%0d cyc=%0d val=50",
                 i, vld_idx[i], vld_cyc[i], vld_val[i], i, (i + 1) * TERMS + 1);
      end
    end
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (fm_out[k] !== 32'd50) begin failures++; $display("FAIL ones_fm_out[%0d]: got %0d expected 50", k, fm_out[k]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ones_busy_after: got %b expected 0", busy); end
    $display("test_all_ones done: done_cycle=%0d valids=%0d", obs_done_cycle, vld_idx.size());
  endtask

  task automatic test_scaled();
    fill_fm(32'd1);
    for (int k = 0; k < NK; k++) fill_kern(k, 32'(k));
    run_layer(N + 2, 0, 0);
    checks++; if (obs_done_cycle != N + 1) begin failures++; $display("FAIL scaled_done_cycle: got %0d expected %0d", obs_done_cycle, N + 1); end
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (fm_out[k] !== 32'(50 * k)) begin failures++; $display("FAIL scaled_fm_out[%0d]: got %0d expected %0d", k, fm_out[k], 50 * k); end
    end
    $display("test_scaled done: fm_out[9]=%0d", fm_out[9]);
  endtask

  task automatic test_negative();
    logic [BW-1:0] exp3;
`ifdef CONV_LAYER_SEQ_RELU_EN
    exp3 = 32'h0;
`else
    exp3 = 32'hFFFF_FFCE;
`endif
    fill_fm(32'd1);
    for (int k = 0; k < NK; k++) fill_kern(k, 32'd1);
    fill_kern(3, 32'hFFFF_FFFF);
    run_layer(N + 2, 0, 0);
    checks++; if (fm_out[3] !== exp3) begin failures++; $display("FAIL negative_fm_out[3]: got %h expected %h", fm_out[3], exp3); end
    checks++; if (fm_out[4] !== 32'd50) begin failures++; $display("FAIL negative_fm_out[4]: got %0d expected 50", fm_out[4]); end
    $display("test_negative done: fm_out[3]=%h", fm_out[3]);
  endtask

  task automatic test_wrap();
    fill_fm(32'h0001_0000);
    for (int k = 0; k < NK; k++) fill_kern(k, 32'h0001_0000);
    run_layer(N + 2, 0, 0);
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (fm_out[k] !== '0) begin failures++; $display("FAIL wrap_fm_out[%0d]: got %h expected 0", k, fm_out[k]); end
    end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < CH; c++)
        for (int r = 0; r < KS; r++)
          for (int x = 0; x < KS; x++) begin
            fm[c][r][x] = (it == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
            for (int k = 0; k < NK; k++)
              kern[k][c][r][x] = (it == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
          end
      model();
      run_layer(N + 2, 0, 0);
      checks++; if (vld_val.size() != NK) begin failures++; $display("FAIL random%0d_valid_count: got %0d expected %0d", it, vld_val.size(), NK); end
      for (int k = 0; k < NK; k++) begin
        checks++;
        if (fm_out[k] !== expv[k]) begin failures++; $display("FAIL random%0d_fm_out[%0d]: got %h expected %h", it, k, fm_out[k], expv[k]); end
        if (k < vld_val.size()) begin
          checks++;
          if (vld_val[k] !== expv[vld_idx[k]]) begin failures++; $display("FAIL random%0d_valid_val[%0d]: got %h expected %h", it, k, vld_val[k], expv[vld_idx[k]]); end
        end
      end
      $display("test_random iteration %0d done: fm_out[0]=%h", it, fm_out[0]);
    end
  endtask

  task automatic test_restart_ignored();
    fill_fm(32'd1);
    for (int k = 0; k < NK; k++) fill_kern(k, 32'd1);
    run_layer(N + 10, 50, 0);
    checks++; if (obs_done_cycle != N + 1) begin failures++; $display("FAIL restart_run_done_cycle: got %0d expected %0d", obs_done_cycle, N + 1); end
    checks++; if (obs_done_count != 1) begin failures++; $display("FAIL restart_run_done_count: got %0d expected 1", obs_done_count); end
    checks++; if (vld_idx.size() != NK) begin failures++; $display("FAIL restart_run_valid_count: got %0d expected %0d", vld_idx.size(), NK); end
    $display("test_restart_ignored (RUN) done: done_cycle=%0d", obs_done_cycle);
    run_layer(N + 10, N + 1, 0);
    checks++; if (obs_done_count != 1) begin failures++; $display("FAIL restart_done_done_count: got %0d expected 1", obs_done_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL restart_done_busy_after: got %b expected 0", busy); end
    $display("test_restart_ignored (DONE) done: busy=%b", busy);
  endtask

  task automatic test_mid_reset();
    fill_fm(32'd1);
    for (int k = 0; k < NK; k++) fill_kern(k, 32'd2);
    run_layer(110, 0, 100);
    checks++; if (obs_done_count != 0) begin failures++; $display("FAIL midreset_done_count: got %0d expected 0", obs_done_count); end
    checks++; if (vld_idx.size() != 1) begin failures++; $display("FAIL midreset_valid_count: got %0d expected 1", vld_idx.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (fm_out[k] !== '0) begin failures++; $display("FAIL midreset_fm_out[%0d]: got %h expected 0", k, fm_out[k]); end
    end
    $display("test_mid_reset abort done");
    for (int k = 0; k < NK; k++) fill_kern(k, 32'd1);
    run_layer(N + 2, 0, 0);
    checks++; if (obs_done_cycle != N + 1) begin failures++; $display("FAIL midreset_rerun_done_cycle: got %0d expected %0d", obs_done_cycle, N + 1); end
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (fm_out[k] !== 32'd50) begin failures++; $display("FAIL midreset_rerun_fm_out[%0d]: got %0d expected 50", k, fm_out[k]); end
    end
    $display("test_mid_reset rerun done");
  endtask

  task automatic test_back_to_back();
    fill_fm(32'd1);
    for (int k = 0; k < NK; k++) fill_kern(k, 32'(k));
    run_layer(N + 1, 0, 0);
    checks++; if (obs_done_cycle != N + 1) begin failures++; $display("FAIL b2b_first_done_cycle: got %0d expected %0d", obs_done_cycle, N + 1); end
    checks++; if (fm_out[9] !== 32'd450) begin failures++; $display("FAIL b2b_first_fm_out[9]: got %0d expected 450", fm_out[9]); end
    @(negedge clk);
    for (int k = 0; k < NK; k++) fill_kern(k, 32'd1);
    run_layer(N + 2, 0, 0);
    checks++; if (obs_busy1 !== 1'b1) begin failures++; $display("FAIL b2b_second_accepted: got %b expected 1", obs_busy1); end
    checks++; if (obs_done_cycle != N + 1) begin failures++; $display("FAIL b2b_second_done_cycle: got %0d expected %0d", obs_done_cycle, N + 1); end
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (fm_out[k] !== 32'd50) begin failures++; $display("FAIL b2b_second_fm_out[%0d]: got %0d expected 50", k, fm_out[k]); end
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    fill_fm('0);
    for (int k = 0; k < NK; k++) fill_kern(k, '0);
    test_reset();
    test_all_ones();
    test_scaled();
    test_negative();
    test_wrap();
    test_random();
    test_restart_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
